mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 51 +++++
 rtl/mem_arbiter_rr_arb2.sv | 26 ++
 rtl/mem_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared types and constants for the IFU/LSU memory arbiter: FSM state and
// owner encodings, bus widths, reset values of the registered request
// payload and the default response timeout.
// ---------------------------------------------------------------------------
package mem_arbiter_pkg;

    localparam int unsigned ADDR_WIDTH      = 32;
    localparam int unsigned DATA_WIDTH      = 32;
    localparam int unsigned MASK_WIDTH      = DATA_WIDTH / 8;
    localparam int unsigned TIMEOUT_CYC_DEF = 255;

    localparam logic [ADDR_WIDTH-1:0] ADDR_INIT = '0;
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = '0;
    localparam logic [MASK_WIDTH-1:0] MASK_ZERO = '0;

    // Arbiter FSM: at most one transaction in flight.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2
    } arb_state_e;

    // Owner of the in-flight transaction; also used as the last-grant pointer.
    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_e;

    // Request payload presented on the memory port.
    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic                  wr_en;
        logic [DATA_WIDTH-1:0] wr_data;
        logic [MASK_WIDTH-1:0] wr_mask;
    } mem_req_t;

    localparam mem_req_t MEM_REQ_INIT = '{
        addr:    ADDR_INIT,
        wr_en:   1'b0,
        wr_data: DATA_ZERO,
        wr_mask: MASK_ZERO
    };

    // One-hot grant {lsu, ifu} to owner encoding.
    function automatic owner_e grant_owner(input logic [1:0] grant);
        return grant[1] ? OWN_LSU : OWN_IFU;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin selector. A lone valid requester always wins; on a tie
// the requester that was not granted last wins.
// Ports:
//   ifu_valid, lsu_valid : request valids
//   last_grant           : owner granted most recently
//   grant_c              : one-hot grant, bit 0 = IFU, bit 1 = LSU
// ---------------------------------------------------------------------------
module rr_arb2
    import mem_arbiter_pkg::*;
(
    input  logic       ifu_valid,
    input  logic       lsu_valid,
    input  owner_e     last_grant,
    output logic [1:0] grant_c
);

    // Fairness only matters when both ask; otherwise pass the lone valid.
    always_comb begin
        grant_c    = 2'b00;
        grant_c[0] = ifu_valid && (!lsu_valid || (last_grant == OWN_LSU));
        grant_c[1] = lsu_valid && (!ifu_valid || (last_grant == OWN_IFU));
    end

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Arbitrates the IFU (read-only) and LSU (read/write) request ports onto a
// single memory port with at most one outstanding transaction. Responses are
// routed back to the owner as a one-cycle pulse; a response that does not
// arrive within TIMEOUT_CYC response-wait cycles is answered with err=1.
// Ports:
//   i_sys_clk, i_sys_rst            : clock, synchronous active-high reset
//   i_ifu_req_valid/o_ifu_req_ready : IFU request handshake, i_ifu_addr
//   o_ifu_rsp_valid/_data/_err      : IFU response
//   i_lsu_req_valid/o_lsu_req_ready : LSU request handshake, i_lsu_addr,
//                                     i_lsu_wr_en/_wr_data/_wr_mask
//   o_lsu_rsp_valid/_data/_err      : LSU response
//   o_mem_req_valid/i_mem_req_ready : memory request handshake, o_mem_addr,
//                                     o_mem_wr_en/_wr_data/_wr_mask
//   i_mem_rsp_valid/i_mem_rsp_data  : memory response (reads and writes)
// ---------------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                  i_sys_clk,
    input  logic                  i_sys_rst,

    input  logic                  i_ifu_req_valid,
    output logic                  o_ifu_req_ready,
    input  logic [ADDR_WIDTH-1:0] i_ifu_addr,
    output logic                  o_ifu_rsp_valid,
    output logic [DATA_WIDTH-1:0] o_ifu_rsp_data,
    output logic                  o_ifu_rsp_err,

    input  logic                  i_lsu_req_valid,
    output logic                  o_lsu_req_ready,
    input  logic [ADDR_WIDTH-1:0] i_lsu_addr,
    input  logic                  i_lsu_wr_en,
    input  logic [DATA_WIDTH-1:0] i_lsu_wr_data,
    input  logic [MASK_WIDTH-1:0] i_lsu_wr_mask,
    output logic                  o_lsu_rsp_valid,
    output logic [DATA_WIDTH-1:0] o_lsu_rsp_data,
    output logic                  o_lsu_rsp_err,

    output logic                  o_mem_req_valid,
    input  logic                  i_mem_req_ready,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic                  o_mem_wr_en,
    output logic [DATA_WIDTH-1:0] o_mem_wr_data,
    output logic [MASK_WIDTH-1:0] o_mem_wr_mask,
    input  logic                  i_mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] i_mem_rsp_data
);

    // A zero timeout disables the counter; keep it one bit wide so it exists.
    localparam int unsigned CNT_W     = (TIMEOUT_CYC == 0) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned TO_LAST_I = (TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_LAST_I);
    localparam logic [CNT_W-1:0] TO_MAX  = CNT_W'(TIMEOUT_CYC);
    localparam bit               TO_EN   = (TIMEOUT_CYC != 0);

    arb_state_e            state_q;
    owner_e                owner_q;
    owner_e                last_grant_q;
    mem_req_t              req_q;
    logic                  mem_req_valid_q;
    logic [CNT_W-1:0]      to_cnt_q;

    logic                  ifu_rsp_valid_q;
    logic [DATA_WIDTH-1:0] ifu_rsp_data_q;
    logic                  ifu_rsp_err_q;
    logic                  lsu_rsp_valid_q;
    logic [DATA_WIDTH-1:0] lsu_rsp_data_q;
    logic                  lsu_rsp_err_q;

    logic [1:0]            grant_c;
    logic                  idle_c;
    mem_req_t              ifu_pay_c;
    mem_req_t              lsu_pay_c;
    mem_req_t              grant_pay_c;
    logic                  to_hit_c;
    logic                  rsp_fire_c;
    logic                  rsp_err_c;
    logic [DATA_WIDTH-1:0] rsp_data_c;

    rr_arb2 u_rr_arb2 (
        .ifu_valid  (i_ifu_req_valid),
        .lsu_valid  (i_lsu_req_valid),
        .last_grant (last_grant_q),
        .grant_c    (grant_c)
    );

    // Ready is only offered in IDLE and never while reset is asserted.
    assign idle_c          = (state_q == ST_IDLE) && !i_sys_rst;
    assign o_ifu_req_ready = idle_c && grant_c[0];
    assign o_lsu_req_ready = idle_c && grant_c[1];

    // Candidate payloads; IFU fetches are always reads with an empty mask.
    always_comb begin
        ifu_pay_c         = MEM_REQ_INIT;
        ifu_pay_c.addr    = i_ifu_addr;

        lsu_pay_c         = MEM_REQ_INIT;
        lsu_pay_c.addr    = i_lsu_addr;
        lsu_pay_c.wr_en   = i_lsu_wr_en;
        lsu_pay_c.wr_data = i_lsu_wr_data;
        lsu_pay_c.wr_mask = i_lsu_wr_mask;

        grant_pay_c       = grant_c[1] ? lsu_pay_c : ifu_pay_c;
    end

    // The timeout fires on the TIMEOUT_CYC-th consecutive RSP cycle without a
    // response, i.e. as the counter is about to reach TIMEOUT_CYC.
    assign to_hit_c = TO_EN && (to_cnt_q == TO_LAST);

    // Response source for the current RSP cycle: real data or a timeout error.
    always_comb begin
        rsp_fire_c = 1'b0;
        rsp_err_c  = 1'b0;
        rsp_data_c = i_mem_rsp_data;
        if (state_q == ST_RSP) begin
            if (i_mem_rsp_valid) begin
                rsp_fire_c = 1'b1;
            end else if (to_hit_c) begin
                rsp_fire_c = 1'b1;
                rsp_err_c  = 1'b1;
                rsp_data_c = DATA_ZERO;
            end
        end
    end

    // Arbiter FSM with registered memory request and response outputs.
    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            state_q         <= ST_IDLE;
            owner_q         <= OWN_IFU;
            last_grant_q    <= OWN_IFU;
            req_q           <= MEM_REQ_INIT;
            mem_req_valid_q <= 1'b0;
            to_cnt_q        <= '0;
            ifu_rsp_valid_q <= 1'b0;
            ifu_rsp_data_q  <= DATA_ZERO;
            ifu_rsp_err_q   <= 1'b0;
            lsu_rsp_valid_q <= 1'b0;
            lsu_rsp_data_q  <= DATA_ZERO;
            lsu_rsp_err_q   <= 1'b0;
        end else begin
            // Response valids are single-cycle pulses.
            ifu_rsp_valid_q <= 1'b0;
            lsu_rsp_valid_q <= 1'b0;

            unique case (state_q)
                ST_IDLE: begin
                    if (|grant_c) begin
                        owner_q         <= grant_owner(grant_c);
                        last_grant_q    <= grant_owner(grant_c);
                        req_q           <= grant_pay_c;
                        mem_req_valid_q <= 1'b1;
                        state_q         <= ST_REQ;
                    end
                end

                ST_REQ: begin
                    if (i_mem_req_ready) begin
                        mem_req_valid_q <= 1'b0;
                        to_cnt_q        <= '0;
                        state_q         <= ST_RSP;
                    end
                end

                ST_RSP: begin
                    if (rsp_fire_c) begin
                        if (owner_q == OWN_LSU) begin
                            lsu_rsp_valid_q <= 1'b1;
                            lsu_rsp_data_q  <= rsp_data_c;
                            lsu_rsp_err_q   <= rsp_err_c;
                        end else begin
                            ifu_rsp_valid_q <= 1'b1;
                            ifu_rsp_data_q  <= rsp_data_c;
                            ifu_rsp_err_q   <= rsp_err_c;
                        end
                        to_cnt_q <= '0;
                        state_q  <= ST_IDLE;
                    end else if (TO_EN && (to_cnt_q != TO_MAX)) begin
                        to_cnt_q <= to_cnt_q + CNT_W'(1);
                    end
                end

                default: begin
                    state_q         <= ST_IDLE;
                    mem_req_valid_q <= 1'b0;
                    to_cnt_q        <= '0;
                end
            endcase
        end
    end

    assign o_mem_req_valid = mem_req_valid_q;
    assign o_mem_addr      = req_q.addr;
    assign o_mem_wr_en     = req_q.wr_en;
    assign o_mem_wr_data   = req_q.wr_data;
    assign o_mem_wr_mask   = req_q.wr_mask;

    assign o_ifu_rsp_valid = ifu_rsp_valid_q;
    assign o_ifu_rsp_data  = ifu_rsp_data_q;
    assign o_ifu_rsp_err   = ifu_rsp_err_q;
    assign o_lsu_rsp_valid = lsu_rsp_valid_q;
    assign o_lsu_rsp_data  = lsu_rsp_data_q;
    assign o_lsu_rsp_err   = lsu_rsp_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
// Directed, table-driven bench for mem_arbiter plus hand-written sequences
// for timeout, stray responses and reset in the middle of a transaction.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int unsigned TO = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  ifu_req_valid, ifu_req_ready;
    logic [ADDR_WIDTH-1:0] ifu_addr;
    logic                  ifu_rsp_valid, ifu_rsp_err;
    logic [DATA_WIDTH-1:0] ifu_rsp_data;
    logic                  lsu_req_valid, lsu_req_ready;
    logic [ADDR_WIDTH-1:0] lsu_addr;
    logic                  lsu_wr_en;
    logic [DATA_WIDTH-1:0] lsu_wr_data;
    logic [MASK_WIDTH-1:0] lsu_wr_mask;
    logic                  lsu_rsp_valid, lsu_rsp_err;
    logic [DATA_WIDTH-1:0] lsu_rsp_data;
    logic                  mem_req_valid, mem_req_ready;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_wr_en;
    logic [DATA_WIDTH-1:0] mem_wr_data;
    logic [MASK_WIDTH-1:0] mem_wr_mask;
    logic                  mem_rsp_valid;
    logic [DATA_WIDTH-1:0] mem_rsp_data;

    always #5 clk = ~clk;

    mem_arbiter #(.TIMEOUT_CYC(TO)) dut (
        .i_sys_clk       (clk),
        .i_sys_rst       (rst),
        .i_ifu_req_valid (ifu_req_valid),
        .o_ifu_req_ready (ifu_req_ready),
        .i_ifu_addr      (ifu_addr),
        .o_ifu_rsp_valid (ifu_rsp_valid),
        .o_ifu_rsp_data  (ifu_rsp_data),
        .o_ifu_rsp_err   (ifu_rsp_err),
        .i_lsu_req_valid (lsu_req_valid),
        .o_lsu_req_ready (lsu_req_ready),
        .i_lsu_addr      (lsu_addr),
        .i_lsu_wr_en     (lsu_wr_en),
        .i_lsu_wr_data   (lsu_wr_data),
        .i_lsu_wr_mask   (lsu_wr_mask),
        .o_lsu_rsp_valid (lsu_rsp_valid),
        .o_lsu_rsp_data  (lsu_rsp_data),
        .o_lsu_rsp_err   (lsu_rsp_err),
        .o_mem_req_valid (mem_req_valid),
        .i_mem_req_ready (mem_req_ready),
        .o_mem_addr      (mem_addr),
        .o_mem_wr_en     (mem_wr_en),
        .o_mem_wr_data   (mem_wr_data),
        .o_mem_wr_mask   (mem_wr_mask),
        .i_mem_rsp_valid (mem_rsp_valid),
        .i_mem_rsp_data  (mem_rsp_data)
    );

    typedef struct {
        logic        ifu_v;
        logic        lsu_v;
        logic [31:0] ifu_a;
        logic [31:0] lsu_a;
        logic        lsu_we;
        logic [31:0] wdata;
        logic [3:0]  mask;
        int unsigned stall;
        logic [31:0] rdata;
        logic        exp_lsu;
    } vec_t;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;
    logic [31:0] exp_ifu_data;
    logic [31:0] exp_lsu_data;
    vec_t        vecs[7];
    vec_t        v_post;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h want 0x%08h", name, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        ifu_req_valid = 1'b0; ifu_addr = '0;
        lsu_req_valid = 1'b0; lsu_addr = '0; lsu_wr_en = 1'b0;
        lsu_wr_data = '0; lsu_wr_mask = '0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    endtask

    // Full transaction from IDLE: grant, stalled REQ, handshake, response, hold.
    task automatic run_txn(input vec_t v, input string tag);
        logic [31:0] e_addr, e_wd;
        logic        e_we;
        logic [3:0]  e_mask;
        e_addr = v.exp_lsu ? v.lsu_a : v.ifu_a;
        e_we   = v.exp_lsu & v.lsu_we;
        e_wd   = v.exp_lsu ? v.wdata : 32'h0;
        e_mask = v.exp_lsu ? v.mask : 4'h0;

        ifu_req_valid = v.ifu_v; ifu_addr = v.ifu_a;
        lsu_req_valid = v.lsu_v; lsu_addr = v.lsu_a; lsu_wr_en = v.lsu_we;
        lsu_wr_data = v.wdata; lsu_wr_mask = v.mask;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
        #1;
        check({tag, ".ifu_ready"}, 32'(ifu_req_ready), 32'(!v.exp_lsu));
        check({tag, ".lsu_ready"}, 32'(lsu_req_ready), 32'(v.exp_lsu));
        step();
        check({tag, ".req_valid"}, 32'(mem_req_valid), 32'h1);
        check({tag, ".req_addr"},  mem_addr, e_addr);
        check({tag, ".req_we"},    32'(mem_wr_en), 32'(e_we));
        check({tag, ".req_wdata"}, mem_wr_data, e_wd);
        check({tag, ".req_mask"},  32'(mem_wr_mask), 32'(e_mask));
        check({tag, ".ready_in_req"}, 32'({ifu_req_ready, lsu_req_ready}), 32'h0);
        for (int i = 0; i < int'(v.stall); i++) begin
            step();
            check({tag, ".stall_valid"}, 32'(mem_req_valid), 32'h1);
            check({tag, ".stall_addr"},  mem_addr, e_addr);
            check({tag, ".stall_wdata"}, mem_wr_data, e_wd);
        end
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0; ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        check({tag, ".req_done"}, 32'(mem_req_valid), 32'h0);
        mem_rsp_valid = 1'b1; mem_rsp_data = v.rdata;
        step();
        mem_rsp_valid = 1'b0; mem_rsp_data = 32'hFFFF_FFFF;
        if (v.exp_lsu) exp_lsu_data = v.rdata;
        else           exp_ifu_data = v.rdata;
        check({tag, ".ifu_rsp_v"}, 32'(ifu_rsp_valid), 32'(!v.exp_lsu));
        check({tag, ".lsu_rsp_v"}, 32'(lsu_rsp_valid), 32'(v.exp_lsu));
        check({tag, ".rsp_data"}, v.exp_lsu ? lsu_rsp_data : ifu_rsp_data, v.rdata);
        check({tag, ".rsp_err"},  32'(v.exp_lsu ? lsu_rsp_err : ifu_rsp_err), 32'h0);
        step();
        check({tag, ".pulse_end"}, 32'({ifu_rsp_valid, lsu_rsp_valid}), 32'h0);
        check({tag, ".ifu_hold"}, ifu_rsp_data, exp_ifu_data);
        check({tag, ".lsu_hold"}, lsu_rsp_data, exp_lsu_data);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    initial begin
        //          ifu  lsu  ifu_a         lsu_a         we    wdata         mask  st rdata         exp_lsu
        vecs[0] = '{1'b1, 1'b1, 32'h0000_0100, 32'h0000_0200, 1'b0, 32'h0,        4'h0, 0, 32'hA0A0_0001, 1'b1};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_0104, 32'h0000_0204, 1'b0, 32'h0,        4'h0, 0, 32'hA0A0_0002, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 32'h0000_0108, 32'h0000_0208, 1'b1, 32'h5555_AAAA, 4'h3, 0, 32'h0000_0003, 1'b1};
        vecs[3] = '{1'b1, 1'b0, 32'h8000_0000, 32'h0,         1'b0, 32'h0,        4'h0, 0, 32'h1234_5678, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 32'h0,         32'h0000_0010, 1'b1, 32'hDEAD_BEEF, 4'hF, 4, 32'h0000_0000, 1'b1};
        vecs[5] = '{1'b1, 1'b1, 32'h0000_0020, 32'h0000_0030, 1'b0, 32'h0,        4'h0, 0, 32'h0BAD_F00D, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 32'h0,         32'h0000_0044, 1'b0, 32'h0,        4'h0, 1, 32'hCAFE_0006, 1'b1};
        v_post  = '{1'b1, 1'b0, 32'h0000_0070, 32'h0,         1'b0, 32'h0,        4'h0, 0, 32'h600D_0001, 1'b0};

        // Reset: no ready even with both requesting, all outputs zero.
        drive_idle();
        rst = 1'b1;
        ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
        #1;
        check("rst.ready", 32'({ifu_req_ready, lsu_req_ready}), 32'h0);
        step();
        step();
        check("rst.ready_held", 32'({ifu_req_ready, lsu_req_ready}), 32'h0);
        check("rst.mem_valid", 32'(mem_req_valid), 32'h0);
        check("rst.mem_addr", mem_addr, 32'h0);
        check("rst.rsp_valid", 32'({ifu_rsp_valid, lsu_rsp_valid, ifu_rsp_err, lsu_rsp_err}), 32'h0);
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        rst = 1'b0;
        step();
        check("post_rst.mem", 32'({mem_req_valid, mem_wr_en, mem_wr_mask}), 32'h0);
        check("post_rst.rsp_data", ifu_rsp_data | lsu_rsp_data, 32'h0);
        exp_ifu_data = 32'h0;
        exp_lsu_data = 32'h0;

        // Stray response in IDLE is dropped.
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'hFFFF_0000;
        step();
        mem_rsp_valid = 1'b0;
        step();
        check("stray_idle.rsp_v", 32'({ifu_rsp_valid, lsu_rsp_valid}), 32'h0);
        check("stray_idle.data", ifu_rsp_data | lsu_rsp_data, 32'h0);
        check("stray_idle.mem_valid", 32'(mem_req_valid), 32'h0);

        for (int i = 0; i < 7; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

        // Timeout: LSU read never answered.
        lsu_req_valid = 1'b1; lsu_addr = 32'h0000_0050; lsu_wr_en = 1'b0;
        lsu_wr_data = '0; lsu_wr_mask = '0;
        #1;
        check("to.lsu_ready", 32'(lsu_req_ready), 32'h1);
        step();
        lsu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        check("to.rsp_r1", 32'(lsu_rsp_valid), 32'h0);
        for (int k = 0; k < 3; k++) begin
            step();
            check("to.rsp_early", 32'(lsu_rsp_valid), 32'h0);
        end
        step();
        check("to.lsu_rsp_v", 32'(lsu_rsp_valid), 32'h1);
        check("to.lsu_err", 32'(lsu_rsp_err), 32'h1);
        check("to.lsu_data", lsu_rsp_data, 32'h0);
        check("to.ifu_rsp_v", 32'(ifu_rsp_valid), 32'h0);
        exp_lsu_data = 32'h0;
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'h7777_7777;
        step();
        mem_rsp_valid = 1'b0;
        check("late.rsp_v", 32'({ifu_rsp_valid, lsu_rsp_valid}), 32'h0);
        step();
        check("late.rsp_v2", 32'({ifu_rsp_valid, lsu_rsp_valid}), 32'h0);
        check("late.lsu_data", lsu_rsp_data, exp_lsu_data);
        check("late.ifu_data", ifu_rsp_data, exp_ifu_data);

        // Reset while waiting in RSP: abandoned, no response, later stray dropped.
        ifu_req_valid = 1'b1; ifu_addr = 32'h0000_0060;
        step();
        ifu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        rst = 1'b1;
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'h9999_9999;
        step();
        check("rst_rsp.rsp_v", 32'({ifu_rsp_valid, lsu_rsp_valid}), 32'h0);
        check("rst_rsp.mem_valid", 32'(mem_req_valid), 32'h0);
        check("rst_rsp.ifu_data", ifu_rsp_data, 32'h0);
        check("rst_rsp.lsu_data", lsu_rsp_data, 32'h0);
        check("rst_rsp.mem_addr", mem_addr, 32'h0);
        rst = 1'b0;
        step();
        mem_rsp_valid = 1'b0;
        check("rst_rsp.stray", 32'({ifu_rsp_valid, lsu_rsp_valid}), 32'h0);
        step();
        check("rst_rsp.stray2", 32'({ifu_rsp_valid, lsu_rsp_valid}), 32'h0);
        exp_ifu_data = 32'h0;
        exp_lsu_data = 32'h0;
        run_txn(v_post, "post_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
